muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU. It takes a single-cycle start request from EX, runs signed or unsigned multiply, multiply-accumulate/subtract, or divide over a fixed number of cycles, and commits the 2×WIDTH result into HI/LO. It supports pipeline flush and direct HI/LO writes (MTHI/MTLO), and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be even and ≥ 8.
- MUL_BITS, 2, multiplier bits retired per cycle; legal values are 1, 2 and 4; must divide WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only when busy=0 and flush=0.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- a, b  in  WIDTH  operands; a is the dividend, b is the divisor.
- flush  in  1  aborts any operation in flight; blocks acceptance this cycle.
- wr_hi, wr_lo  in  1  direct write enables; honoured only when busy=0.
- wr_data  in  WIDTH  data for wr_hi/wr_lo.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO already hold the new result.
- hi, lo  out  WIDTH  architectural HI/LO register values.

## Operation
- State machine:
  - IDLE -> MUL on an accepted op 0/1/4..7.
  - IDLE -> DIV on an accepted op 2/3.
  - MUL/DIV -> FIX when the iteration counter expires.
  - FIX -> IDLE. FIX applies sign correction and accumulation, writes HI/LO and raises done.
- Operand capture: a, b and op are registered at the acceptance edge. Later input changes have no effect.
- Signed ops:
  - Operands are converted to magnitudes at capture.
  - Multiply: the product is negated in FIX if a[W-1]^b[W-1].
  - Divide: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
- Multiply: shift-add, MUL_BITS bits per cycle, 2W-bit accumulator.
- MADD/MSUB: {hi,lo} = {hi,lo} ± product, modulo 2^(2W).
  - The product is signed for MADD/MSUB and unsigned for MADDU/MSUBU.
  - The {hi,lo} base is sampled at the acceptance edge. If wr_hi/wr_lo is asserted in the acceptance cycle, the written value is forwarded into the base.
- Divide: restoring radix-2, one quotient bit per cycle. Result is lo = quotient, hi = remainder.
- Divide by zero: lo = all-ones, hi = a (the raw operand), for both DIV and DIVU. Latency is normal. No exception is raised here.
- DIV of the most negative value by -1: lo = the most negative value, hi = 0 (natural wrap).
- Direct writes:
  - wr_hi/wr_lo update hi/lo at the next edge when busy=0.
  - Writes while busy=1 are dropped.
  - A write in the done cycle is legal and applies on top of the result.
- Flush:
  - Returns the FSM to IDLE at the next edge with hi/lo unchanged and no done pulse.
  - flush together with start: the start is dropped.
- start while busy=1: ignored, with no side effects.
- Reset (rst=0): immediately forces IDLE, hi=0, lo=0, busy=0, done=0. This applies mid-operation too; the in-flight result is lost.

## Timing
- Acceptance edge E0 = the rising edge where start=1, busy=0 and flush=0. busy=1 from E0 until the commit edge.
- Latency L, in edges from E0 to the commit edge E0+L:
  - Multiply family: L = WIDTH/MUL_BITS + 1, which is 17 at the defaults.
  - Divide: L = WIDTH + 1, which is 33.
- In the cycle after E0+L: done=1, busy=0, and hi/lo hold the result.
- A new start in the done cycle is accepted, giving back-to-back operation without a bubble.
- done lasts exactly one cycle, and only for completed (unflushed) operations.
- Flush sampled at edge Ef: busy=0 in the cycle after Ef.
- Outputs hi, lo, busy and done are all registered; there is no combinational path from the inputs.

## Test plan
- MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done exactly 17 cycles after the start edge. MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 33 cycles. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- wr_lo=1 with wr_data=1 and MADD a=2, b=3 started in the same cycle -> lo=7, hi=0. With hi=lo=0, MSUBU a=1, b=1 -> hi=lo=0xFFFFFFFF.
- Flush in the 10th busy cycle of a DIV -> no done pulse, hi/lo unchanged, busy=0 next cycle. A start pulsed while busy is ignored, and the original result still commits on schedule.
- Back-to-back: a start in the done cycle of a MULTU is accepted. wr_hi while busy is dropped.
- rst=0 asserted asynchronously mid-MULT -> hi=lo=0 and busy=done=0 immediately. After release, a new op completes normally.
- Sweep MUL_BITS=1/4 and WIDTH=16 with random signed/unsigned ops against a reference model, checking exact latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / multiply-accumulate / divide unit that owns
// the architectural HI/LO pair. Multiplies retire MUL_BITS multiplier bits per
// cycle; divides are restoring radix-2. Results are sign-corrected and
// accumulated in a final FIX cycle, which commits HI/LO and pulses done.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int MUL_ITERS = WIDTH / MUL_BITS;
  localparam int DIV_ITERS = WIDTH;
  localparam int CNT_W     = $clog2(WIDTH + 1);
  localparam int W2        = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  // Two's-complement negation when en is set (single width).
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // Two's-complement negation when en is set (double width).
  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // Control state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // Captured operation and datapath
  logic [2:0]       op_q;
  logic             neg_q;      // negate product / quotient
  logic             neg_rem_q;  // negate remainder (dividend sign)
  logic             dvz_q;      // divisor was zero
  logic [W2-1:0]    opa_q;      // multiplicand (shifts left) or raw dividend for div-by-zero
  logic [WIDTH-1:0] opb_q;      // multiplier (shifts right) or divisor magnitude
  logic [W2-1:0]    acc_q;      // product accumulator, or {remainder, quotient}
  logic [W2-1:0]    base_q;     // {hi,lo} base for MADD/MSUB

  logic             accept, in_div, in_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    pp;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    prod, res;
  logic [WIDTH:0]   trial, diff;

  assign accept = start_i && !flush_i && (state_q == S_IDLE);
  assign in_div = (op_i[2:1] == 2'b01);
  assign in_sgn = ~op_i[0];
  assign a_mag  = neg_w(a_i, in_sgn & a_i[WIDTH-1]);
  assign b_mag  = neg_w(b_i, in_sgn & b_i[WIDTH-1]);

  // Partial product for the MUL_BITS multiplier bits retired this cycle
  always_comb begin
    pp = '0;
    for (int k = 0; k < MUL_BITS; k++) begin
      if (opb_q[k]) pp = pp + (opa_q << k);
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if no borrow
  always_comb begin
    trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff  = trial - {1'b0, opb_q};
    if (!diff[WIDTH]) begin
      div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result: sign correction, accumulation and the divide-by-zero override
  always_comb begin
    prod = neg_2w(acc_q, neg_q);
    if (op_q[2]) begin
      res = op_q[1] ? (base_q - prod) : (base_q + prod);
    end else begin
      res = prod;
    end
    if (op_q[2:1] == 2'b01) begin
      if (dvz_q) begin
        res = {opa_q[WIDTH-1:0], {WIDTH{1'b1}}};
      end else begin
        res = {neg_w(acc_q[W2-1:WIDTH], neg_rem_q), neg_w(acc_q[WIDTH-1:0], neg_q)};
      end
    end
  end

  // Next-state, iteration counter, HI/LO update and done generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_hi_i) hi_d = wr_data_i;
        if (wr_lo_i) lo_d = wr_data_i;
        if (accept) begin
          state_d = in_div ? S_DIV : S_MUL;
          cnt_d   = in_div ? CNT_W'(DIV_ITERS - 1) : CNT_W'(MUL_ITERS - 1);
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        state_d = S_IDLE;
        hi_d    = res[W2-1:WIDTH];
        lo_d    = res[WIDTH-1:0];
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush kills whatever is in flight, including a pending commit
    if (flush_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // Control and architectural registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Operand capture at acceptance, then one iteration per cycle
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q      <= op_i;
      neg_q     <= in_sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      neg_rem_q <= in_sgn & a_i[WIDTH-1];
      dvz_q     <= (b_i == '0);
      opb_q     <= b_mag;
      base_q    <= {(wr_hi_i ? wr_data_i : hi_q), (wr_lo_i ? wr_data_i : lo_q)};
      if (in_div) begin
        opa_q <= {{WIDTH{1'b0}}, a_i};
        acc_q <= {{WIDTH{1'b0}}, a_mag};
      end else begin
        opa_q <= {{WIDTH{1'b0}}, a_mag};
        acc_q <= '0;
      end
    end else if (state_q == S_MUL) begin
      acc_q <= acc_q + pp;
      opa_q <= opa_q << MUL_BITS;
      opb_q <= opb_q >> MUL_BITS;
    end else if (state_q == S_DIV) begin
      acc_q <= div_next;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases at WIDTH=32/MUL_BITS=2
// plus randomized operations on three configurations against an arithmetic model.
module tb_muldiv_unit;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start [NI];
  logic        flush [NI];
  logic        wrhi  [NI];
  logic        wrlo  [NI];
  logic [2:0]  op    [NI];
  logic [31:0] a     [NI];
  logic [31:0] b     [NI];
  logic [31:0] wd    [NI];
  wire         busy  [NI];
  wire         done  [NI];
  wire  [31:0] hi    [NI];
  wire  [31:0] lo    [NI];

  logic [31:0] mhi [NI];
  logic [31:0] mlo [NI];

  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] hi0, lo0;
  logic [15:0] hi1, lo1, hi2, lo2;

  int n_tests;
  int n_fail;

  muldiv_unit #(.WIDTH(32), .MUL_BITS(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .op_i(op[0]), .a_i(a[0]), .b_i(b[0]),
    .flush_i(flush[0]), .wr_hi_i(wrhi[0]), .wr_lo_i(wrlo[0]), .wr_data_i(wd[0]),
    .busy_o(busy0), .done_o(done0), .hi_o(hi0), .lo_o(lo0));

  muldiv_unit #(.WIDTH(16), .MUL_BITS(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .op_i(op[1]), .a_i(a[1][15:0]), .b_i(b[1][15:0]),
    .flush_i(flush[1]), .wr_hi_i(wrhi[1]), .wr_lo_i(wrlo[1]), .wr_data_i(wd[1][15:0]),
    .busy_o(busy1), .done_o(done1), .hi_o(hi1), .lo_o(lo1));

  muldiv_unit #(.WIDTH(16), .MUL_BITS(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .op_i(op[2]), .a_i(a[2][15:0]), .b_i(b[2][15:0]),
    .flush_i(flush[2]), .wr_hi_i(wrhi[2]), .wr_lo_i(wrlo[2]), .wr_data_i(wd[2][15:0]),
    .busy_o(busy2), .done_o(done2), .hi_o(hi2), .lo_o(lo2));

  assign busy[0] = busy0;
  assign busy[1] = busy1;
  assign busy[2] = busy2;
  assign done[0] = done0;
  assign done[1] = done1;
  assign done[2] = done2;
  assign hi[0]   = hi0;
  assign lo[0]   = lo0;
  assign hi[1]   = {16'h0, hi1};
  assign lo[1]   = {16'h0, lo1};
  assign hi[2]   = {16'h0, hi2};
  assign lo[2]   = {16'h0, lo2};

  function automatic int w_of(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic int mb_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: result of one operation at width w given the HI/LO base
  function automatic void model(int w, logic [2:0] o, logic [31:0] av, logic [31:0] bv,
                                logic [31:0] bh, logic [31:0] bl,
                                output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] m1, m2, ua, ub, base, p, res;
    longint      sa, sb, q, r;
    m1   = (64'd1 << w) - 64'd1;
    m2   = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    ua   = {32'h0, av} & m1;
    ub   = {32'h0, bv} & m1;
    sa   = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
    sb   = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
    base = (({32'h0, bh} & m1) << w) | ({32'h0, bl} & m1);
    if (o == 3'd2 || o == 3'd3) begin
      if (ub == 64'd0) begin
        res = (ua << w) | m1;
      end else if (o == 3'd2) begin
        q   = sa / sb;
        r   = sa % sb;
        res = ((64'(r) & m1) << w) | (64'(q) & m1);
      end else begin
        res = ((ua % ub) << w) | (ua / ub);
      end
    end else begin
      if (o[0]) p = ua * ub;
      else      p = 64'(sa * sb);
      if (!o[2])     res = p;
      else if (o[1]) res = base - p;
      else           res = base + p;
      res = res & m2;
    end
    rh = 32'((res >> w) & m1);
    rl = 32'(res & m1);
  endfunction

  function automatic logic [31:0] pick(int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return m;
      3:       return 32'h1 << (w - 1);
      4:       return (32'h1 << (w - 1)) - 32'h1;
      default: return $urandom & m;
    endcase
  endfunction

  // Launch one operation (called at a negedge while idle), wait for done, check it.
  // disturb pokes start and direct writes while busy; both must be ignored.
  task automatic run_op(int k, logic [2:0] o, logic [31:0] av, logic [31:0] bv,
                        bit whi, bit wlo, logic [31:0] wdv, bit disturb);
    logic [31:0] rh, rl, bh, bl;
    int n, lat, w;
    w   = w_of(k);
    bh  = whi ? wdv : mhi[k];
    bl  = wlo ? wdv : mlo[k];
    model(w, o, av, bv, bh, bl, rh, rl);
    lat = (o[2:1] == 2'b01) ? (w + 1) : (w / mb_of(k) + 1);
    start[k] = 1'b1; op[k] = o; a[k] = av; b[k] = bv;
    wrhi[k] = whi; wrlo[k] = wlo; wd[k] = wdv;
    @(posedge clk);
    @(negedge clk);
    start[k] = 1'b0; wrhi[k] = 1'b0; wrlo[k] = 1'b0;
    n = 1;
    chk("busy_after_start", 64'(busy[k]), 64'd1);
    chk("done_one_cycle", 64'(done[k]), 64'd0);
    while (!done[k] && n < 200) begin
      if (disturb && n == 3) begin
        start[k] = 1'b1; op[k] = 3'($urandom); a[k] = $urandom; b[k] = $urandom;
        wrhi[k] = 1'b1; wrlo[k] = 1'b1; wd[k] = $urandom;
      end
      if (disturb && n == 4) begin
        start[k] = 1'b0; wrhi[k] = 1'b0; wrlo[k] = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n - 1), 64'(lat));
    chk("busy_in_done", 64'(busy[k]), 64'd0);
    chk("hi", 64'(hi[k]), 64'(rh));
    chk("lo", 64'(lo[k]), 64'(rl));
    mhi[k] = rh;
    mlo[k] = rl;
  endtask

  task automatic write_hl(int k, bit whi, bit wlo, logic [31:0] v);
    logic [31:0] m;
    m = (w_of(k) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    wrhi[k] = whi; wrlo[k] = wlo; wd[k] = v;
    @(posedge clk);
    @(negedge clk);
    wrhi[k] = 1'b0; wrlo[k] = 1'b0;
    if (whi) mhi[k] = v & m;
    if (wlo) mlo[k] = v & m;
    chk("direct_hi", 64'(hi[k]), 64'(mhi[k]));
    chk("direct_lo", 64'(lo[k]), 64'(mlo[k]));
  endtask

  initial begin
    bit          seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb, rw;
    int          sel;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0; flush[k] = 1'b0; wrhi[k] = 1'b0; wrlo[k] = 1'b0;
      op[k] = 3'd0; a[k] = 32'h0; b[k] = 32'h0; wd[k] = 32'h0;
      mhi[k] = 32'h0; mlo[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      chk("reset_hi", 64'(hi[k]), 64'd0);
      chk("reset_lo", 64'(lo[k]), 64'd0);
      chk("reset_busy", 64'(busy[k]), 64'd0);
      chk("reset_done", 64'(done[k]), 64'd0);
    end

    // Directed cases at the default configuration
    run_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'h0, 0);
    chk("mult_hi_const", 64'(hi[0]), 64'hFFFF_FFFF);
    chk("mult_lo_const", 64'(lo[0]), 64'hFFFF_FFFA);
    run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'h0, 0);
    chk("multu_hi_const", 64'(hi[0]), 64'hFFFF_FFFE);
    chk("multu_lo_const", 64'(lo[0]), 64'h0000_0001);
    run_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'h0, 0);
    chk("div_neg7_lo", 64'(lo[0]), 64'hFFFF_FFFD);
    chk("div_neg7_hi", 64'(hi[0]), 64'hFFFF_FFFF);
    run_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 0);
    chk("div_ovf_lo", 64'(lo[0]), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi[0]), 64'h0);
    run_op(0, 3'd3, 32'd5, 32'd0, 0, 0, 32'h0, 0);
    chk("divu_zero_lo", 64'(lo[0]), 64'hFFFF_FFFF);
    chk("divu_zero_hi", 64'(hi[0]), 64'd5);
    run_op(0, 3'd2, 32'hFFFF_FFF0, 32'd0, 0, 0, 32'h0, 0);
    chk("div_zero_raw_hi", 64'(hi[0]), 64'hFFFF_FFF0);

    write_hl(0, 1, 0, 32'h0);
    run_op(0, 3'd4, 32'd2, 32'd3, 0, 1, 32'd1, 0);
    chk("madd_fwd_lo", 64'(lo[0]), 64'd7);
    chk("madd_fwd_hi", 64'(hi[0]), 64'd0);
    write_hl(0, 1, 1, 32'h0);
    run_op(0, 3'd7, 32'd1, 32'd1, 0, 0, 32'h0, 0);
    chk("msubu_hi", 64'(hi[0]), 64'hFFFF_FFFF);
    chk("msubu_lo", 64'(lo[0]), 64'hFFFF_FFFF);

    // Start and direct writes while busy are ignored; result commits on schedule
    run_op(0, 3'd0, 32'd12345, 32'hFFFF_FFFD, 0, 0, 32'h0, 1);
    // Back-to-back: each launch below happens in the done cycle of the previous op
    run_op(0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 32'h0, 0);
    run_op(0, 3'd6, 32'h0000_0100, 32'hFFFF_FFFF, 0, 0, 32'h0, 1);

    // Flush during the 10th busy cycle of a DIV
    start[0] = 1'b1; op[0] = 3'd2; a[0] = 32'd1000; b[0] = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b0;
    chk("flush_busy", 64'(busy[0]), 64'd0);
    chk("flush_done", 64'(done[0]), 64'd0);
    chk("flush_hi", 64'(hi[0]), 64'(mhi[0]));
    chk("flush_lo", 64'(lo[0]), 64'(mlo[0]));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen = 1'b1;
    end
    chk("flush_no_done_later", 64'(seen), 64'd0);
    chk("flush_hi_later", 64'(hi[0]), 64'(mhi[0]));

    // Flush together with start drops the start
    start[0] = 1'b1; flush[0] = 1'b1; op[0] = 3'd0; a[0] = 32'd3; b[0] = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0; flush[0] = 1'b0;
    chk("flush_start_dropped", 64'(busy[0]), 64'd0);

    // Asynchronous reset in the middle of a MULT
    write_hl(0, 1, 1, 32'hA5A5_5A5A);
    start[0] = 1'b1; op[0] = 3'd0; a[0] = 32'h1234; b[0] = 32'h5678;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", 64'(hi[0]), 64'd0);
    chk("arst_lo", 64'(lo[0]), 64'd0);
    chk("arst_busy", 64'(busy[0]), 64'd0);
    chk("arst_done", 64'(done[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      mhi[k] = 32'h0;
      mlo[k] = 32'h0;
    end
    run_op(0, 3'd0, 32'h0000_0007, 32'hFFFF_FFFA, 0, 0, 32'h0, 0);

    // Randomized operations on all three configurations
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 40; i++) begin
        ro  = 3'($urandom_range(0, 7));
        ra  = pick(w_of(k));
        rb  = pick(w_of(k));
        rw  = $urandom;
        sel = $urandom_range(0, 7);
        run_op(k, ro, ra, rb, sel == 0, sel == 1, rw, sel == 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
